// File: rtl/debug_register_reader.sv
// Captures the register-file debug snapshot on a start request and streams a chosen
// index range out one word per valid/ready transfer.
module debug_register_reader #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] debug_registers,
  input  logic                           start,
  input  logic [INDEX_WIDTH-1:0]         first_index,
  input  logic [INDEX_WIDTH-1:0]         last_index,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INDEX_WIDTH-1:0]         out_index,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e                 state;
  logic [DATA_WIDTH-1:0]  snapshot  [NUM_REGS];
  logic [DATA_WIDTH-1:0]  bus_words [NUM_REGS];
  logic [INDEX_WIDTH-1:0] last_q;
  logic [INDEX_WIDTH-1:0] next_index;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      bus_words[i] = debug_registers[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign next_index = out_index + INDEX_WIDTH'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      snapshot  <= '{default: '0};
      last_q    <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            snapshot <= bus_words;
            last_q   <= last_index;
            busy     <= 1'b1;
            if (first_index <= last_index) begin
              // First word comes straight off the bus since the snapshot loads on this edge.
              state     <= StStream;
              out_valid <= 1'b1;
              out_index <= first_index;
              out_data  <= bus_words[first_index];
              out_last  <= (first_index == last_index);
            end else begin
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StStream: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= StDone;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_index <= next_index;
              out_data  <= snapshot[next_index];
              out_last  <= (next_index == last_q);
            end
          end
        end
        StDone: begin
          state <= StIdle;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
